vstu_burst_tracker: RTL and testbench

// Completion tracker downstream of the vector store unit's W channel, on the AXI B channel.

---
 rtl/vstu_burst_tracker.sv | 144 ++++++++++++++
 tb/tb_vstu_burst_tracker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vstu_burst_tracker.sv
// Completion tracker for vector stores on the AXI B channel.
// Each accepted store holds an entry that counts the AW bursts issued for it and
// the B responses returned for it. The store retires in order, reporting its id and a
// sticky error flag, only after it has issued its last burst and every burst is acknowledged.
module vstu_burst_tracker #(
    parameter int unsigned Depth    = 4,
    parameter int unsigned NrVInsn  = 8,
    parameter int unsigned CntWidth = 8,
    localparam int unsigned IdW     = (NrVInsn > 1) ? $clog2(NrVInsn) : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           insn_valid_i,
    input  logic [IdW-1:0] insn_id_i,
    input  logic           insn_empty_i,
    output logic           insn_ready_o,
    input  logic           aw_valid_i,
    input  logic           aw_last_i,
    output logic           aw_ready_o,
    input  logic           b_valid_i,
    input  logic [1:0]     b_resp_i,
    output logic           b_ready_o,
    output logic           done_valid_o,
    output logic [IdW-1:0] done_id_o,
    output logic           done_err_o,
    output logic           pending_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [Depth-1:0]    valid_q;
    logic [Depth-1:0]    aw_done_q;
    logic [Depth-1:0]    err_q;
    logic [IdW-1:0]      id_q     [Depth];
    logic [CntWidth-1:0] issued_q [Depth];
    logic [CntWidth-1:0] acked_q  [Depth];

    logic [PtrW-1:0] wr_pnt_q;
    logic [PtrW-1:0] hd_pnt_q;
    logic [CntW-1:0] count_q;

    logic [PtrW-1:0] aw_pnt;
    logic            aw_exists;
    logic            accept;
    logic            aw_fire;
    logic            b_fire;
    logic            retire;

    // The AW target is found by scanning from the head, so zero-burst stores
    // (already aw_done at accept) are skipped without any extra cycle of latency.
    always_comb begin
        aw_pnt    = hd_pnt_q;
        aw_exists = 1'b0;
        for (int unsigned k = 0; k < Depth; k++) begin
            logic [PtrW-1:0] idx;
            idx = hd_pnt_q + PtrW'(k);
            if (!aw_exists && (CntW'(k) < count_q) && !aw_done_q[idx]) begin
                aw_pnt    = idx;
                aw_exists = 1'b1;
            end
        end
    end

    // Handshake readies and the retire decision, all from registered state.
    always_comb begin
        insn_ready_o = (count_q != CntW'(Depth));
        aw_ready_o   = aw_exists && (issued_q[aw_pnt] != '1);
        b_ready_o    = valid_q[hd_pnt_q] && (acked_q[hd_pnt_q] != issued_q[hd_pnt_q]);
        retire       = valid_q[hd_pnt_q] && aw_done_q[hd_pnt_q] &&
                       (acked_q[hd_pnt_q] == issued_q[hd_pnt_q]);
        accept       = insn_valid_i && insn_ready_o;
        aw_fire      = aw_valid_i && aw_ready_o;
        b_fire       = b_valid_i && b_ready_o;
        pending_o    = (count_q != '0);
    end

    // Entry table: accept writes the tail, AW bumps the AW target, B bumps the head, retire frees the head.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= '0;
            aw_done_q <= '0;
            err_q     <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                id_q[i]     <= '0;
                issued_q[i] <= '0;
                acked_q[i]  <= '0;
            end
        end else begin
            if (aw_fire) begin
                issued_q[aw_pnt] <= issued_q[aw_pnt] + CntWidth'(1);
                if (aw_last_i) aw_done_q[aw_pnt] <= 1'b1;
            end
            if (b_fire) begin
                acked_q[hd_pnt_q] <= acked_q[hd_pnt_q] + CntWidth'(1);
                err_q[hd_pnt_q]   <= err_q[hd_pnt_q] | b_resp_i[1];
            end
            if (retire) valid_q[hd_pnt_q] <= 1'b0;
            if (accept) begin
                valid_q[wr_pnt_q]   <= 1'b1;
                id_q[wr_pnt_q]      <= insn_id_i;
                issued_q[wr_pnt_q]  <= '0;
                acked_q[wr_pnt_q]   <= '0;
                aw_done_q[wr_pnt_q] <= insn_empty_i;
                err_q[wr_pnt_q]     <= 1'b0;
            end
        end
    end

    // Write/head pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_pnt_q <= '0;
            hd_pnt_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_pnt_q <= wr_pnt_q + PtrW'(1);
            if (retire) hd_pnt_q <= hd_pnt_q + PtrW'(1);
            case ({accept, retire})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered completion report, one cycle after the retire.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_valid_o <= 1'b0;
            done_id_o    <= '0;
            done_err_o   <= 1'b0;
        end else begin
            done_valid_o <= retire;
            done_id_o    <= retire ? id_q[hd_pnt_q] : '0;
            done_err_o   <= retire && err_q[hd_pnt_q];
        end
    end

    // An AW burst with no store waiting for bursts is a protocol error upstream.
    aw_without_store : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(aw_valid_i && !aw_exists));

endmodule

// File: tb/tb_vstu_burst_tracker.sv
// Randomized bench for vstu_burst_tracker against a transaction-level store model.
module tb_vstu_burst_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       insn_valid, insn_empty, aw_valid, aw_last, b_valid;
    logic [2:0] insn_id;
    logic [1:0] b_resp;
    logic       insn_ready, aw_ready, b_ready, done_valid, done_err, pending;
    logic [2:0] done_id;

    vstu_burst_tracker #(.Depth(4), .NrVInsn(8), .CntWidth(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .insn_valid_i (insn_valid),
        .insn_id_i    (insn_id),
        .insn_empty_i (insn_empty),
        .insn_ready_o (insn_ready),
        .aw_valid_i   (aw_valid),
        .aw_last_i    (aw_last),
        .aw_ready_o   (aw_ready),
        .b_valid_i    (b_valid),
        .b_resp_i     (b_resp),
        .b_ready_o    (b_ready),
        .done_valid_o (done_valid),
        .done_id_o    (done_id),
        .done_err_o   (done_err),
        .pending_o    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned id;
        int unsigned nb;
        int unsigned issued;
        int unsigned acked;
        bit          aw_done;
        bit          err;
    } store_t;

    store_t      stores[$];
    int unsigned bresp_q[$];
    int unsigned cur_id, cur_nb;
    bit          exp_dv, exp_derr;
    int unsigned exp_did;
    int unsigned checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_plan();
        cur_id = $urandom_range(0, 7);
        cur_nb = $urandom_range(0, 4);
    endtask

    // One cycle: check outputs against the model at negedge, drive inputs, then advance the model.
    task automatic step(input int unsigned p_acc, input int unsigned p_aw, input int unsigned p_b);
        int  ai;
        bit  e_ir, e_awr, e_br, e_ret;
        store_t t;
        @(negedge clk);
        ai = -1;
        foreach (stores[i]) if (ai < 0 && !stores[i].aw_done) ai = i;
        e_ir  = stores.size() != 4;
        e_awr = ai >= 0;
        e_br  = stores.size() > 0 && stores[0].acked != stores[0].issued;
        e_ret = stores.size() > 0 && stores[0].aw_done && stores[0].acked == stores[0].issued;
        check("insn_ready", insn_ready, e_ir);
        check("aw_ready", aw_ready, e_awr);
        check("b_ready", b_ready, e_br);
        check("pending", pending, stores.size() != 0);
        check("done_valid", done_valid, exp_dv);
        if (exp_dv) begin
            check("done_id", done_id, exp_did);
            check("done_err", done_err, exp_derr);
        end
        insn_valid = $urandom_range(0, 99) < p_acc;
        insn_id    = cur_id[2:0];
        insn_empty = cur_nb == 0;
        aw_valid   = e_awr && ($urandom_range(0, 99) < p_aw);
        aw_last    = (ai >= 0) ? (stores[ai].issued + 1 == stores[ai].nb) : 1'b0;
        b_valid    = bresp_q.size() > 0 && ($urandom_range(0, 99) < p_b);
        b_resp     = (bresp_q.size() > 0) ? bresp_q[0][1:0] : 2'($urandom_range(0, 3));
        @(posedge clk);
        exp_dv = e_ret;
        if (e_ret) begin
            exp_did  = stores[0].id;
            exp_derr = stores[0].err;
        end
        if (aw_valid && e_awr) begin
            t = stores[ai];
            t.issued++;
            if (aw_last) t.aw_done = 1'b1;
            stores[ai] = t;
            // Mostly OKAY/EXOKAY, sometimes SLVERR/DECERR.
            bresp_q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1));
        end
        if (b_valid && e_br) begin
            t = stores[0];
            t.acked++;
            t.err = t.err | bresp_q[0][1];
            stores[0] = t;
            void'(bresp_q.pop_front());
        end
        if (e_ret) void'(stores.pop_front());
        if (insn_valid && e_ir) begin
            stores.push_back('{id: cur_id, nb: cur_nb, issued: 0, acked: 0, aw_done: cur_nb == 0, err: 1'b0});
            new_plan();
        end
    endtask

    task automatic run_phase(input int unsigned n, input int unsigned pa, input int unsigned pw, input int unsigned pb);
        for (int unsigned c = 0; c < n; c++) step(pa, pw, pb);
    endtask

    initial begin
        rst_n = 1'b0; insn_valid = 1'b0; insn_id = '0; insn_empty = 1'b0;
        aw_valid = 1'b0; aw_last = 1'b0; b_valid = 1'b0; b_resp = '0;
        exp_dv = 1'b0; exp_did = 0; exp_derr = 1'b0;
        new_plan();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done_valid", done_valid, 1'b0);
        check("rst_pending", pending, 1'b0);
        check("rst_insn_ready", insn_ready, 1'b1);
        check("rst_aw_ready", aw_ready, 1'b0);
        check("rst_b_ready", b_ready, 1'b0);
        rst_n = 1'b1;

        run_phase(300, 50, 60, 60);
        run_phase(200, 95, 30, 10);   // keep the table full
        run_phase(200, 30, 90, 90);
        run_phase(200, 80, 80, 80);

        // Mid-operation reset with at least two stores outstanding.
        for (int unsigned c = 0; c < 200 && stores.size() < 2; c++) step(90, 20, 20);
        check("pre_reset_outstanding", stores.size() >= 2, 1'b1);
        @(negedge clk);
        insn_valid = 1'b0; aw_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_done_valid", done_valid, 1'b0);
        check("midrst_pending", pending, 1'b0);
        check("midrst_b_ready", b_ready, 1'b0);
        check("midrst_aw_ready", aw_ready, 1'b0);
        stores.delete();
        bresp_q.delete();
        exp_dv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_phase(5, 0, 0, 0);

        run_phase(300, 60, 70, 70);
        for (int unsigned c = 0; c < 300 && stores.size() != 0; c++) step(0, 90, 90);
        step(0, 0, 0);
        check("drained", pending, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
